// File: rtl/regfile_port_arbiter_if.sv
// regfile_port_arbiter_if
//   Bundles the two requester handshakes and the register-file port signals
//   seen by regfile_port_arbiter.
//   slave  : arbiter side (consumes requests and rf_data_out; drives acks,
//            read data, regfile write/read controls and busy)
//   master : environment side (requesters plus the register file instance)
// Signals
//   req0/we0/num0/wdata0 -> ack0/rdata0   requester 0 (datapath controller)
//   req1/we1/num1/wdata1 -> ack1/rdata1   requester 1 (debug scan)
//   rf_readnum, rf_writenum, rf_write, rf_data_in -> register file
//   rf_data_out <- register file (combinational read)
//   busy         arbiter not idle
interface regfile_port_arbiter_if #(
  parameter int DW = 16,
  parameter int NW = 3
);
  logic          req0;
  logic          we0;
  logic [NW-1:0] num0;
  logic [DW-1:0] wdata0;
  logic          ack0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          we1;
  logic [NW-1:0] num1;
  logic [DW-1:0] wdata1;
  logic          ack1;
  logic [DW-1:0] rdata1;

  logic [NW-1:0] rf_readnum;
  logic [NW-1:0] rf_writenum;
  logic          rf_write;
  logic [DW-1:0] rf_data_in;
  logic [DW-1:0] rf_data_out;

  logic          busy;

  modport slave (
    input  req0, we0, num0, wdata0,
    input  req1, we1, num1, wdata1,
    input  rf_data_out,
    output ack0, rdata0, ack1, rdata1,
    output rf_readnum, rf_writenum, rf_write, rf_data_in,
    output busy
  );

  modport master (
    output req0, we0, num0, wdata0,
    output req1, we1, num1, wdata1,
    output rf_data_out,
    input  ack0, rdata0, ack1, rdata1,
    input  rf_readnum, rf_writenum, rf_write, rf_data_in,
    input  busy
  );
endinterface

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
//   Shares the register file's single read port and single write port between
//   requester 0 (datapath controller) and requester 1 (debug scan). One read
//   or write per req/ack transaction, round-robin grant on ties, regfile
//   controls and returned read data are all registered.
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    regfile_port_arbiter_if.slave (requester handshakes, regfile
//          ports, busy)
//
// State table
//   state | meaning
//   IDLE  | sample requests, grant one and latch its transaction fields
//   ISSUE | drive regfile port for one cycle (write strobe / read capture)
//   ACK   | ack pulse to the granted requester, requests ignored
module regfile_port_arbiter #(
  parameter int DW = 16,
  parameter int NW = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          gid_q;
  logic          we_q;
  logic          last_grant_q;
  logic          ack0_q, ack1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic [NW-1:0] rf_readnum_q, rf_writenum_q;
  logic [DW-1:0] rf_data_in_q;

  logic          grant;
  logic          grant_id;
  logic          g_we;
  logic [NW-1:0] g_num;
  logic [DW-1:0] g_wdata;

  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    grant_id = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant = 1'b1;
          // On a tie the requester that did not win last time goes next.
          grant_id = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
          state_d  = ISSUE;
        end
      end
      ISSUE:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    g_we    = grant_id ? bus.we1    : bus.we0;
    g_num   = grant_id ? bus.num1   : bus.num0;
    g_wdata = grant_id ? bus.wdata1 : bus.wdata0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      gid_q         <= 1'b0;
      we_q          <= 1'b0;
      last_grant_q  <= 1'b1;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      rf_readnum_q  <= '0;
      rf_writenum_q <= '0;
      rf_data_in_q  <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        gid_q        <= grant_id;
        we_q         <= g_we;
        last_grant_q <= grant_id;
        rf_readnum_q <= g_num;
        if (g_we) begin
          rf_writenum_q <= g_num;
          rf_data_in_q  <= g_wdata;
        end
      end
      if (state_q == ISSUE) begin
        if (!we_q) begin
          if (gid_q) rdata1_q <= bus.rf_data_out;
          else       rdata0_q <= bus.rf_data_out;
        end
        if (gid_q) ack1_q <= 1'b1;
        else       ack0_q <= 1'b1;
      end
      if (state_q == ACK) begin
        ack0_q <= 1'b0;
        ack1_q <= 1'b0;
      end
    end
  end

  // Gating with reset keeps a reset edge landing in ISSUE from committing
  // the pending write into the (non-reset) register file.
  assign bus.rf_write    = (state_q == ISSUE) && we_q && !reset;
  assign bus.rf_readnum  = rf_readnum_q;
  assign bus.rf_writenum = rf_writenum_q;
  assign bus.rf_data_in  = rf_data_in_q;
  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.rdata0      = rdata0_q;
  assign bus.rdata1      = rdata1_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_regfile_port_arbiter.sv
module tb_regfile_port_arbiter;
  localparam int DW = 16;
  localparam int NW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_port_arbiter_if #(.DW(DW), .NW(NW)) bus ();

  regfile_port_arbiter #(.DW(DW), .NW(NW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Register file instance model: not reset, combinational read.
  logic [DW-1:0] rf_mem [8];
  always @(posedge clk) if (bus.rf_write) rf_mem[bus.rf_writenum] <= bus.rf_data_in;
  assign bus.rf_data_out = rf_mem[bus.rf_readnum];

  // Transaction-level reference model.
  logic [DW-1:0] ref_rf [8];
  logic [DW-1:0] exp_rdata [2];
  logic [NW-1:0] exp_wnum;
  logic [DW-1:0] exp_din;
  int            exp_last;
  int            n_checks = 0;
  int            n_fail   = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", tag, what, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic rq, input logic we,
                         input logic [NW-1:0] num, input logic [DW-1:0] wd);
    if (r == 0) begin
      bus.req0 = rq; bus.we0 = we; bus.num0 = num; bus.wdata0 = wd;
    end else begin
      bus.req1 = rq; bus.we1 = we; bus.num1 = num; bus.wdata1 = wd;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check(tag, "ack0", bus.ack0, 0);
    check(tag, "ack1", bus.ack1, 0);
    check(tag, "busy", bus.busy, 0);
    check(tag, "rf_write", bus.rf_write, 0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    exp_wnum = '0; exp_din = '0; exp_last = 1;
    check_idle_outputs("reset");
    check("reset", "rdata0", bus.rdata0, 0);
    check("reset", "rdata1", bus.rdata1, 0);
    check("reset", "rf_readnum", bus.rf_readnum, 0);
    check("reset", "rf_writenum", bus.rf_writenum, 0);
    check("reset", "rf_data_in", bus.rf_data_in, 0);
    reset = 1'b0;
  endtask

  // Called at a negedge with the DUT idle and at least one request driven.
  // Predicts the winner, follows it through ISSUE and ACK, returns at the
  // negedge after the arbiter is back in IDLE.
  task automatic serve_one(input bit drop, input bit scramble, input string tag);
    int            w;
    logic          we;
    logic [NW-1:0] num;
    logic [DW-1:0] wd;
    if (bus.req0 && bus.req1) w = 1 - exp_last;
    else                      w = bus.req1 ? 1 : 0;
    we  = w ? bus.we1    : bus.we0;
    num = w ? bus.num1   : bus.num0;
    wd  = w ? bus.wdata1 : bus.wdata0;
    if (we) begin exp_wnum = num; exp_din = wd; end

    @(posedge clk); @(negedge clk);
    check(tag, "issue_busy", bus.busy, 1);
    check(tag, "issue_rf_write", bus.rf_write, we);
    check(tag, "issue_readnum", bus.rf_readnum, num);
    check(tag, "issue_writenum", bus.rf_writenum, exp_wnum);
    check(tag, "issue_data_in", bus.rf_data_in, exp_din);
    check(tag, "issue_ack0", bus.ack0, 0);
    check(tag, "issue_ack1", bus.ack1, 0);
    check(tag, "issue_rdata0", bus.rdata0, exp_rdata[0]);
    check(tag, "issue_rdata1", bus.rdata1, exp_rdata[1]);
    if (scramble)
      set_req(w, 1'b1, 1'($urandom), NW'($urandom), DW'($urandom));

    @(posedge clk); @(negedge clk);
    if (we) ref_rf[num] = wd;
    else    exp_rdata[w] = ref_rf[num];
    exp_last = w;
    check(tag, "ack_winner", w ? bus.ack1 : bus.ack0, 1);
    check(tag, "ack_other", w ? bus.ack0 : bus.ack1, 0);
    check(tag, "ack_rdata0", bus.rdata0, exp_rdata[0]);
    check(tag, "ack_rdata1", bus.rdata1, exp_rdata[1]);
    check(tag, "ack_rf_write", bus.rf_write, 0);
    check(tag, "ack_busy", bus.busy, 1);
    if (drop) begin
      if (w == 1) bus.req1 = 1'b0;
      else        bus.req0 = 1'b0;
    end

    @(posedge clk); @(negedge clk);
    check_idle_outputs({tag, "_idle"});
  endtask

  initial begin
    reset = 1'b1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 8; i++) begin
      rf_mem[i] = DW'($urandom);
      ref_rf[i] = rf_mem[i];
    end

    // Reset, then idle with no requests.
    do_reset(2);
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      check_idle_outputs("idle_noreq");
    end

    // Write then read back r3 from requester 0.
    set_req(0, 1'b1, 1'b1, 3'd3, 16'hBEEF);
    serve_one(1, 0, "wr_r3");
    set_req(0, 1'b1, 1'b0, 3'd3, 16'h0000);
    serve_one(1, 0, "rd_r3");
    check("rd_r3", "rdata0_value", bus.rdata0, 16'hBEEF);

    // Both requesters held from reset: strict alternation 0,1,0,1.
    set_req(0, 1'b1, 1'b0, 3'd1, '0);
    set_req(1, 1'b1, 1'b0, 3'd2, '0);
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      check("rr", "ack_order_pred", exp_last, (i == 0) ? 1 : ((i - 1) % 2));
      serve_one(0, 0, "rr");
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;

    // Requester 1 writes r7, requester 0 reads it; r0 zero write/readback.
    set_req(1, 1'b1, 1'b1, 3'd7, 16'hFFFF);
    serve_one(1, 0, "wr_r7");
    set_req(0, 1'b1, 1'b0, 3'd7, '0);
    serve_one(1, 0, "rd_r7");
    check("rd_r7", "rdata0_value", bus.rdata0, 16'hFFFF);
    set_req(0, 1'b1, 1'b1, 3'd0, 16'h0000);
    serve_one(1, 0, "wr_r0");
    set_req(0, 1'b1, 1'b0, 3'd0, 16'h5555);
    serve_one(1, 0, "rd_r0");
    check("rd_r0", "rdata0_value", bus.rdata0, 16'h0000);

    // Reset during ISSUE aborts the pending write.
    set_req(0, 1'b1, 1'b1, 3'd5, 16'h1234);
    serve_one(1, 0, "wr_r5");
    set_req(0, 1'b1, 1'b1, 3'd5, 16'h5678);
    @(posedge clk); @(negedge clk);
    check("abort", "issue_rf_write", bus.rf_write, 1);
    reset = 1'b1;
    bus.req0 = 1'b0;
    #1;
    check("abort", "gated_rf_write", bus.rf_write, 0);
    @(posedge clk); @(negedge clk);
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    exp_wnum = '0; exp_din = '0; exp_last = 1;
    check_idle_outputs("abort_reset");
    check("abort_reset", "rdata0", bus.rdata0, 0);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check_idle_outputs("abort_after");
    end
    set_req(0, 1'b1, 1'b0, 3'd5, '0);
    serve_one(1, 0, "rd_r5");
    check("rd_r5", "rdata0_value", bus.rdata0, 16'h1234);

    // Held request through ACK: serviced once per 3-cycle window.
    set_req(0, 1'b1, 1'b0, 3'd2, '0);
    serve_one(0, 0, "hold1");
    serve_one(1, 0, "hold2");

    // Randomized traffic against the transaction model.
    for (int i = 0; i < 300; i++) begin
      if (!bus.req0 && $urandom_range(0, 1) == 1)
        set_req(0, 1'b1, 1'($urandom), NW'($urandom), DW'($urandom));
      if (!bus.req1 && $urandom_range(0, 1) == 1)
        set_req(1, 1'b1, 1'($urandom), NW'($urandom), DW'($urandom));
      if (!bus.req0 && !bus.req1) begin
        @(posedge clk); @(negedge clk);
        check_idle_outputs("rand_idle");
      end else begin
        serve_one(1, 1'($urandom), "rand");
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(posedge clk); @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
